pipeline_result_collector: RTL and testbench
============================================

# pipeline_result_collector

Drains the results FIFO of one aggregating pipeline by driving its `grabResults` read strobe, compensating for the FIFO read latency, and buffering results in a small skid FIFO. Results leave on a valid/ready stream towards the host-side result interface. A per-job counter and wide accumulators track progress, so the job controller sees a single `done` flag once the expected number of results has been delivered.

## Interface
- `PCOEFF_COUNT_BITWIDTH`, 10, count width; sum width is `PCOEFF_COUNT_BITWIDTH+35`.
- `READ_LATENCY`, 2, cycles from `grabResults` high to valid `pcoeffSum`/`pcoeffCount` at the results FIFO; legal range 1..3.
- `SKID_DEPTH_LOG2`, 2, local buffer depth is 2^N = 4 entries; must satisfy 2^N ≥ `READ_LATENCY`+1.
- `clk`  in  1  single clock for the whole block.
- `rstN`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: load `expectedResults` and begin a job.
- `expectedResults`  in  32  number of results in the job.
- `resultsAvailable`  in  1  results FIFO non-empty.
- `grabResults`  out  1  results FIFO read strobe.
- `pcoeffSum`  in  `PCOEFF_COUNT_BITWIDTH+35`  FIFO read data, sum field.
- `pcoeffCount`  in  `PCOEFF_COUNT_BITWIDTH`  FIFO read data, count field.
- `outValid`  out  1  skid buffer head is valid.
- `outReady`  in  1  downstream accepts the head.
- `outSum`  out  `PCOEFF_COUNT_BITWIDTH+35`  head sum field.
- `outCount`  out  `PCOEFF_COUNT_BITWIDTH`  head count field.
- `totalSum`  out  64  running sum of delivered `outSum`, zero-extended.
- `totalCount`  out  32  running sum of delivered `outCount`, zero-extended.
- `delivered`  out  32  number of results delivered in the current job.
- `done`  out  1  high while in state DONE.
- `busy`  out  1  high while in state COLLECT.

## Operation
- States:
  - IDLE (after reset).
  - IDLE/DONE + `start` → COLLECT. Loads `remaining` = `expectedResults`, clears `delivered`, `totalSum` and `totalCount`. If `expectedResults` = 0, the next state is DONE directly.
  - COLLECT, and the `delivered` increment reaches `remaining` → DONE.
  - `start` in COLLECT is ignored.
- `grabResults` is combinational and high when all of the following hold:
  - state = COLLECT;
  - `resultsAvailable`;
  - `inFlight` + `skidOccupancy` < 2^`SKID_DEPTH_LOG2`;
  - `grabbed` < `remaining`.
- `grabbed` counts grabs in the job. It never exceeds `remaining`, so results of the next job stay in the results FIFO.
- A `READ_LATENCY`-deep valid shift register tracks outstanding reads.
  - `inFlight` = number of set bits.
  - When the last stage is set, {`pcoeffSum`, `pcoeffCount`} is written into the skid FIFO in that cycle.
- Credit rule: the skid FIFO can never overflow. An overflow write is a design error and the bench must flag it.
- Output: `outValid` = skid not empty; `outSum`/`outCount` come from the head entry (show-ahead). A pop occurs when `outValid` && `outReady`.
- On each pop:
  - `delivered` increments by 1;
  - `totalSum` += `outSum`;
  - `totalCount` += `outCount`;
  - both accumulators wrap modulo their width.
- Skid write and pop in the same cycle: occupancy unchanged, and both take effect. This also applies when the buffer is full (pop frees an entry that the write fills).
- Asserting `rstN` mid-job clears all state, counters, the shift register and the skid FIFO. In-flight FIFO reads are discarded.

## Timing
- Reset values: `grabResults`=0, `outValid`=0, `outSum`=0, `outCount`=0, `totalSum`=0, `totalCount`=0, `delivered`=0, `done`=0, `busy`=0.
- `start` at edge t: `busy`=1 from t+1. The first `grabResults` can occur in cycle t+1.
- `grabResults` in cycle g: the entry is written at edge g+`READ_LATENCY`, and `outValid`=1 from cycle g+`READ_LATENCY`+1.
- Sustained throughput is 1 result/cycle with `outReady` held high and `resultsAvailable` high.
- The last pop at edge p sets `done`=1 and clears `busy` from cycle p+1. `totalSum`, `totalCount` and `delivered` are final at p+1 and hold until the next `start`.
- `outReady` low: grabs stop once credit is exhausted, with at most 2^`SKID_DEPTH_LOG2` results buffered plus in flight.

## Test plan
- Reset, then `start` with `expectedResults`=3. Three results {sum=5,count=1}, {7,2}, {100,3} are available and `outReady`=1. Required: three grabs on consecutive cycles, `outValid` 3 cycles after the first grab, `totalSum`=112, `totalCount`=6, `delivered`=3, `done`=1.
- `start` with `expectedResults`=0 → `done`=1 one cycle later and `grabResults` never asserted.
- `expectedResults`=10, `outReady` held low for 20 cycles, 10 results available. Required: exactly 4 grabs, no overflow. After `outReady` rises, all 10 results are delivered in order.
- `expectedResults`=2 with 5 results available → exactly 2 grabs; `resultsAvailable` stays high afterwards. A second `start` with 3 drains the rest.
- `rstN` pulsed low with 2 results in flight → all outputs 0 immediately. A subsequent job with `expectedResults`=1 delivers a fresh result only.
- Randomized `outReady`/`resultsAvailable` over 1000 results, checked against a reference model: order preserved, `totalSum` matches the model modulo 2^64, credit never exceeded.

Source files
------------

// File: rtl/pipeline_result_collector.sv
// rtl/pipeline_result_collector.sv - drains a results FIFO through a credited skid buffer
// Per-job delivery counter and wide totals; done rises once every expected result has left.
module pipeline_result_collector #(
  parameter int PCOEFF_COUNT_BITWIDTH = 10,
  parameter int READ_LATENCY          = 2,
  parameter int SKID_DEPTH_LOG2       = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  input  logic [31:0]                       i_expected_results,
  input  logic                              i_results_available,
  output logic                              o_grab_results,
  input  logic [PCOEFF_COUNT_BITWIDTH+34:0] i_pcoeff_sum,
  input  logic [PCOEFF_COUNT_BITWIDTH-1:0]  i_pcoeff_count,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic [PCOEFF_COUNT_BITWIDTH+34:0] o_out_sum,
  output logic [PCOEFF_COUNT_BITWIDTH-1:0]  o_out_count,
  output logic [63:0]                       o_total_sum,
  output logic [31:0]                       o_total_count,
  output logic [31:0]                       o_delivered,
  output logic                              o_done,
  output logic                              o_busy
);

  localparam int SW    = PCOEFF_COUNT_BITWIDTH + 35;
  localparam int CW    = PCOEFF_COUNT_BITWIDTH;
  localparam int EW    = SW + CW;
  localparam int DEPTH = 1 << SKID_DEPTH_LOG2;
  localparam int OCCW  = SKID_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t                     r_state;
  logic                       r_done;
  logic                       r_busy;
  logic [31:0]                r_remaining;
  logic [31:0]                r_grabbed;
  logic [31:0]                r_delivered;
  logic [63:0]                r_total_sum;
  logic [31:0]                r_total_count;
  logic [READ_LATENCY-1:0]    r_rd_pipe;
  logic [EW-1:0]              r_mem [DEPTH];
  logic [SKID_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [SKID_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [OCCW-1:0]            r_occ;

  logic [OCCW-1:0] w_in_flight;
  logic [OCCW:0]   w_credit_used;
  logic            w_grab;
  logic            w_wr;
  logic            w_pop;
  logic            w_out_valid;
  logic [EW-1:0]   w_head;
  logic [SW-1:0]   w_out_sum;
  logic [CW-1:0]   w_out_count;

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_in_flight = w_in_flight + OCCW'(r_rd_pipe[i]);
    end
  end

  // Reads still in flight already own a skid slot, so the buffer can never overflow.
  assign w_credit_used = {1'b0, w_in_flight} + {1'b0, r_occ};
  assign w_grab        = (r_state == S_COLLECT) && i_results_available &&
                         (w_credit_used < (OCCW+1)'(DEPTH)) && (r_grabbed < r_remaining);
  assign w_wr          = r_rd_pipe[READ_LATENCY-1];
  assign w_out_valid   = (r_occ != '0);
  assign w_pop         = w_out_valid && i_out_ready;
  assign w_head        = r_mem[r_rd_ptr];
  assign w_out_sum     = w_out_valid ? w_head[EW-1:CW] : '0;
  assign w_out_count   = w_out_valid ? w_head[CW-1:0]  : '0;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {i_pcoeff_sum, i_pcoeff_count};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_remaining   <= '0;
      r_grabbed     <= '0;
      r_delivered   <= '0;
      r_total_sum   <= '0;
      r_total_count <= '0;
      r_rd_pipe     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_occ         <= '0;
    end else begin
      r_rd_pipe[0] <= w_grab;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end

      if (w_wr)  r_wr_ptr <= r_wr_ptr + SKID_DEPTH_LOG2'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + SKID_DEPTH_LOG2'(1);
      case ({w_wr, w_pop})
        2'b10:   r_occ <= r_occ + OCCW'(1);
        2'b01:   r_occ <= r_occ - OCCW'(1);
        default: r_occ <= r_occ;
      endcase

      if (w_grab) r_grabbed <= r_grabbed + 32'd1;
      if (w_pop) begin
        r_delivered   <= r_delivered + 32'd1;
        r_total_sum   <= r_total_sum + 64'(w_out_sum);
        r_total_count <= r_total_count + 32'(w_out_count);
      end

      case (r_state)
        S_COLLECT: begin
          if (w_pop && ((r_delivered + 32'd1) == r_remaining)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          // Skid and read pipe are empty outside COLLECT, so clearing here races nothing.
          if (i_start) begin
            r_remaining   <= i_expected_results;
            r_grabbed     <= '0;
            r_delivered   <= '0;
            r_total_sum   <= '0;
            r_total_count <= '0;
            if (i_expected_results == 32'd0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_COLLECT;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign o_grab_results = w_grab;
  assign o_out_valid    = w_out_valid;
  assign o_out_sum      = w_out_sum;
  assign o_out_count    = w_out_count;
  assign o_total_sum    = r_total_sum;
  assign o_total_count  = r_total_count;
  assign o_delivered    = r_delivered;
  assign o_done         = r_done;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_pipeline_result_collector.sv
// tb/tb_pipeline_result_collector.sv - self-checking bench for pipeline_result_collector
// Models the latency-L results FIFO and a result-order scoreboard; directed table plus random jobs.
module tb_pipeline_result_collector;

  localparam int CBW   = 10;
  localparam int SW    = CBW + 35;
  localparam int L     = 2;
  localparam int DEPTH = 4;
  localparam int NRAND = 1000;

  typedef struct {
    logic [SW-1:0]  s;
    logic [CBW-1:0] c;
  } res_t;

  typedef struct {
    int              n_exp;
    int              load_first;
    int              load_n;
    int              hold;
    int              hold_grabs;
    int              exp_grabs;
    longint unsigned exp_sum;
    int unsigned     exp_cnt;
    int              exp_left;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start = 1'b0;
  logic [31:0]    expected = '0;
  logic           avail = 1'b0;
  logic           grab;
  logic [SW-1:0]  pc_sum = '0;
  logic [CBW-1:0] pc_cnt = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [SW-1:0]  out_sum;
  logic [CBW-1:0] out_cnt;
  logic [63:0]    total_sum;
  logic [31:0]    total_cnt;
  logic [31:0]    delivered;
  logic           done;
  logic           busy;

  pipeline_result_collector #(
    .PCOEFF_COUNT_BITWIDTH(CBW),
    .READ_LATENCY(L),
    .SKID_DEPTH_LOG2(2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_expected_results(expected),
    .i_results_available(avail),
    .o_grab_results(grab),
    .i_pcoeff_sum(pc_sum),
    .i_pcoeff_count(pc_cnt),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_sum(out_sum),
    .o_out_count(out_cnt),
    .o_total_sum(total_sum),
    .o_total_count(total_cnt),
    .o_delivered(delivered),
    .o_done(done),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   job_grabs = 0;
  int   first_grab_cyc = -1;
  int   last_grab_cyc = -1;
  int   first_valid_cyc = -1;
  int   outstanding = 0;
  int   ready_mode = 0;
  bit   avail_rand = 1'b0;
  res_t fifo_q[$];
  res_t exp_q[$];
  res_t hist_d[L+1];
  bit   hist_v[L+1];
  res_t mon_d;
  res_t mon_e;
  bit   mon_g;
  bit   mon_p;
  res_t D[18];
  res_t R[NRAND];
  vec_t vt[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Results-FIFO model (data appears L cycles after the grab) and in-order scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k <= L; k++) hist_v[k] = 1'b0;
      exp_q.delete();
      outstanding = 0;
    end else begin
      mon_g = grab;
      mon_p = out_valid && out_ready;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (mon_p) begin
        chk("pop_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("pop_sum", out_sum, mon_e.s);
          chk("pop_count", out_cnt, mon_e.c);
        end
      end
      mon_d = '{s: '0, c: '0};
      if (mon_g) begin
        chk("credit", outstanding < DEPTH, 1);
        chk("grab_has_data", fifo_q.size() != 0, 1);
        if (fifo_q.size() != 0) mon_d = fifo_q.pop_front();
        exp_q.push_back(mon_d);
        job_grabs++;
        if (first_grab_cyc < 0) first_grab_cyc = cyc;
        last_grab_cyc = cyc;
      end
      outstanding = outstanding + int'(mon_g) - int'(mon_p);
      for (int k = L; k > 0; k--) begin
        hist_v[k] = hist_v[k-1];
        hist_d[k] = hist_d[k-1];
      end
      hist_v[0] = mon_g;
      hist_d[0] = mon_d;
    end
    if (hist_v[L]) begin
      pc_sum = hist_d[L].s;
      pc_cnt = hist_d[L].c;
    end else begin
      pc_sum = SW'({$urandom(), $urandom()});
      pc_cnt = CBW'($urandom());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    avail = (fifo_q.size() != 0) && (avail_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grab"}, grab, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sum"}, out_sum, 0);
    chk({tag, "_out_count"}, out_cnt, 0);
    chk({tag, "_total_sum"}, total_sum, 0);
    chk({tag, "_total_count"}, total_cnt, 0);
    chk({tag, "_delivered"}, delivered, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_job(input int n, input int hold, input int hold_grabs);
    first_grab_cyc  = -1;
    last_grab_cyc   = -1;
    first_valid_cyc = -1;
    job_grabs       = 0;
    tick();
    start    = 1'b1;
    expected = 32'(n);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, n != 0);
    chk("done_after_start", done, n == 0);
    if (hold > 0) begin
      repeat (hold - 1) tick();
      chk("grabs_while_stalled", job_grabs, hold_grabs);
      ready_mode = 0;
    end
    for (int k = 0; k < 5000 && !done; k++) tick();
    chk("job_done", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint unsigned es;
    int unsigned     ec;
    int              idx;
    int              n;

    D[0] = '{s: 45'd5,   c: 10'd1};
    D[1] = '{s: 45'd7,   c: 10'd2};
    D[2] = '{s: 45'd100, c: 10'd3};
    for (int i = 1; i <= 10; i++) D[2+i] = '{s: SW'(i), c: CBW'(i)};
    for (int i = 0; i < 5; i++) D[13+i] = '{s: SW'(11 + i), c: CBW'(1 + i)};
    //        n  first n   hold hg grabs sum  cnt left
    vt[0] = '{3,  0,    3,  0,   0, 3,    112, 6,  0};
    vt[1] = '{0,  0,    0,  0,   0, 0,    0,   0,  0};
    vt[2] = '{10, 3,    10, 20,  4, 10,   55,  55, 0};
    vt[3] = '{2,  13,   5,  0,   0, 2,    23,  3,  3};
    vt[4] = '{3,  0,    0,  0,   0, 3,    42,  12, 0};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vt[i].load_n; k++) fifo_q.push_back(D[vt[i].load_first + k]);
      ready_mode = (vt[i].hold > 0) ? 1 : 0;
      run_job(vt[i].n_exp, vt[i].hold, vt[i].hold_grabs);
      repeat (2) tick();
      chk("row_total_sum", total_sum, vt[i].exp_sum);
      chk("row_total_count", total_cnt, vt[i].exp_cnt);
      chk("row_delivered", delivered, vt[i].n_exp);
      chk("row_grabs", job_grabs, vt[i].exp_grabs);
      chk("row_busy_clear", busy, 0);
      chk("row_done_held", done, 1);
      chk("row_fifo_left", fifo_q.size(), vt[i].exp_left);
      if (vt[i].exp_grabs > 0 && vt[i].hold == 0) begin
        chk("row_valid_latency", first_valid_cyc - first_grab_cyc, L + 1);
        chk("row_grabs_back_to_back", last_grab_cyc - first_grab_cyc, vt[i].exp_grabs - 1);
      end
    end

    // Reset with two reads in flight: nothing from the aborted job may surface later.
    ready_mode = 1;
    fifo_q.push_back('{s: 45'd20, c: 10'd1});
    fifo_q.push_back('{s: 45'd21, c: 10'd2});
    tick();
    start    = 1'b1;
    expected = 32'd2;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_zero("midjob_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    chk("midjob_fifo_drained", fifo_q.size(), 0);
    fifo_q.push_back('{s: 45'd77, c: 10'd9});
    ready_mode = 0;
    run_job(1, 0, 0);
    chk("fresh_total_sum", total_sum, 77);
    chk("fresh_total_count", total_cnt, 9);
    chk("fresh_delivered", delivered, 1);

    for (int i = 0; i < NRAND; i++) begin
      R[i].s = SW'({$urandom(), $urandom()});
      R[i].c = CBW'($urandom());
      fifo_q.push_back(R[i]);
    end
    ready_mode = 2;
    avail_rand = 1'b1;
    idx = 0;
    while (idx < NRAND) begin
      n = $urandom_range(1, 80);
      if (n > NRAND - idx) n = NRAND - idx;
      es = 0;
      ec = 0;
      for (int k = idx; k < idx + n; k++) begin
        es = es + 64'(R[k].s);
        ec = ec + 32'(R[k].c);
      end
      run_job(n, 0, 0);
      chk("rand_total_sum", total_sum, es);
      chk("rand_total_count", total_cnt, ec);
      chk("rand_delivered", delivered, n);
      chk("rand_grabs", job_grabs, n);
      idx = idx + n;
    end
    tick();
    chk("rand_fifo_empty", fifo_q.size(), 0);
    chk("rand_scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
